// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: state encodings and LED progress patterns for the combination lock
package lock_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GOT1    = 3'd1,
    GOT2    = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;
  localparam logic [3:0] LED_IDLE    = 4'b0001;
  localparam logic [3:0] LED_GOT1    = 4'b0011;
  localparam logic [3:0] LED_GOT2    = 4'b0111;
  localparam logic [3:0] LED_OPEN    = 4'b1111;
  localparam logic [3:0] LED_LOCKOUT = 4'b0000;
  function automatic logic [3:0] led_of(state_e s);
    return s == IDLE ? LED_IDLE : s == GOT1 ? LED_GOT1 : s == GOT2 ? LED_GOT2 :
           s == OPEN ? LED_OPEN : LED_LOCKOUT;
  endfunction
endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: one-cycle press event on each rising edge of a synchronised key level
module key_press_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic key_i,
  output logic press_o
);
  logic key_q;
  assign press_o = key_i & ~key_q & ~Reset;
  // History always follows the key, including during reset, so a held key never fires on release
  always_ff @(posedge Clk) key_q <= key_i;
endmodule

// File: rtl/lock_sequence_controller.sv
// lock_sequence_controller: 3-step keypad code checker with fail lockout; AUTO_RELOCK_EN adds timed relock from OPEN
module lock_sequence_controller
  import lock_ctrl_pkg::*;
#(
  parameter logic [3:0] CODE0          = 4'hD,
  parameter logic [3:0] CODE1          = 4'h7,
  parameter logic [3:0] CODE2          = 4'h9,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 1000,
  parameter int         RELOCK_CYCLES  = 5000,
  parameter int         CNT_W          = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Key1,
  input  logic       Key2,
  input  logic [3:0] Password,
  output logic [3:0] Lock,
  output logic [2:0] Stage,
  output logic       Unlocked,
  output logic       LockedOut,
  output logic [1:0] FailCount
);
  logic press1, press2, exp_key1, hit;
  logic [3:0] exp_code;
  state_e state_q, state_d;
  logic [1:0] fail_q, fail_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  key_press_detect u_key1 (.Clk, .Reset, .key_i(Key1), .press_o(press1));
  key_press_detect u_key2 (.Clk, .Reset, .key_i(Key2), .press_o(press2));

  assign Stage     = state_q;
  assign FailCount = fail_q;

  // Next state: code steps, fail accounting and the shared lockout/relock timer
  always_comb begin
    exp_key1 = state_q != GOT1;
    exp_code = state_q == IDLE ? CODE0 : state_q == GOT1 ? CODE1 : CODE2;
    hit      = (exp_key1 ? press1 & ~press2 : press2 & ~press1) && Password == exp_code;
    state_d  = state_q;
    fail_d   = fail_q;
    timer_d  = '0;
    if (state_q == LOCKOUT) begin
      if (timer_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
        state_d = IDLE;
        fail_d  = '0;
      end else timer_d = timer_q + 1'b1;
    end else if (state_q == OPEN) begin
`ifdef AUTO_RELOCK_EN
      if (timer_q == CNT_W'(RELOCK_CYCLES - 1)) state_d = IDLE;
      else timer_d = timer_q + 1'b1;
`endif
    end else if (press1 | press2) begin
      if (hit) begin
        state_d = state_e'(state_q + 3'd1);
        fail_d  = state_q == GOT2 ? 2'd0 : fail_q;
      end else if (fail_q + 2'd1 == 2'(MAX_FAILS)) begin
        state_d = LOCKOUT;
        fail_d  = 2'(MAX_FAILS);
      end else begin
        state_d = IDLE;
        fail_d  = fail_q + 2'd1;
      end
    end
  end

  // State, counters and output decode all registered from the next state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      fail_q    <= '0;
      timer_q   <= '0;
      Lock      <= LED_IDLE;
      Unlocked  <= 1'b0;
      LockedOut <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      Lock      <= led_of(state_d);
      Unlocked  <= state_d == OPEN;
      LockedOut <= state_d == LOCKOUT;
    end
  end
endmodule
